prep2_capture: RTL and testbench

- Period-capture unit: the measuring end of the PREP-2 timer/counter.
- Watches a single-bit event line, which is typically the compare/reload strobe of a timer/counter.
- Measures the number of CLK cycles between consecutive rising edges and presents each measurement on PERIOD with a VALID/ACK handshake.
- Flags overrun, counter saturation, and a programmable timeout threshold; used in bench harnesses and datapaths that check timer output rates.

---
 rtl/prep_pkg.sv | 12 +
 rtl/prep_sat_counter.sv | 31 +++
 rtl/prep2_capture.sv | 82 ++++++++
 tb/tb_prep2_capture.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prep_pkg.sv
// Shared types and constants for the PREP-2 period-capture block.
package prep_pkg;

    localparam int CAP_WIDTH = 8;
    localparam logic [CAP_WIDTH-1:0] SAT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/prep_sat_counter.sv
// WIDTH-bit saturating up-counter with synchronous clear.
// sat reports that the next increment lands on (or stays at) the ceiling.
module prep_sat_counter
    import prep_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX = '1;

    assign cnt_nxt = (cnt == MAX) ? MAX : cnt + WIDTH'(1);
    assign sat     = (cnt_nxt == MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/prep2_capture.sv
// Period-capture unit: counts CLK cycles between rising edges of EVENT and
// hands each measurement to a consumer over a VALID/ACK handshake.
module prep2_capture
    import prep_pkg::*;
#(
    parameter int WIDTH = CAP_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             EVENT,
    input  logic             ACK,
    input  logic             LDTHR,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] PERIOD,
    output logic             VALID,
    output logic             OVERRUN,
    output logic             SATUR,
    output logic             TIMEOUT
);

    state_t           state;
    logic             event_d;
    logic             evt_rise;
    logic             capture;
    logic             cnt_clr;
    logic             cnt_sat;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] thr;

    assign evt_rise = EVENT & ~event_d;
    assign capture  = (state == ARMED) && EN && evt_rise;
    // Counter only runs while armed; every edge (arming or capturing) restarts it.
    assign cnt_clr  = (state != ARMED) || !EN || evt_rise;
    assign TIMEOUT  = (state == ARMED) && (thr != '0) && (cnt >= thr);

    prep_sat_counter #(.WIDTH(WIDTH)) u_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (cnt_clr),
        .inc     (1'b1),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .sat     (cnt_sat)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            event_d <= 1'b0;
            thr     <= '0;
            PERIOD  <= '0;
            VALID   <= 1'b0;
            OVERRUN <= 1'b0;
            SATUR   <= 1'b0;
        end else begin
            event_d <= EVENT;
            if (LDTHR)
                thr <= DATA;

            case (state)
                IDLE:    if (EN && evt_rise) state <= ARMED;
                ARMED:   if (!EN) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A capture beats a same-cycle ACK; OVERRUN only records loss of an unacked value.
            if (capture) begin
                PERIOD <= cnt_nxt;
                SATUR  <= cnt_sat;
                VALID  <= 1'b1;
                if (VALID && !ACK)
                    OVERRUN <= 1'b1;
            end else if (ACK) begin
                VALID   <= 1'b0;
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prep2_capture.sv
// Directed bench for prep2_capture: period capture, handshake, timeout, saturation.
module tb_prep2_capture;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic         EVENT;
    logic         ACK;
    logic         LDTHR;
    logic [W-1:0] DATA;
    logic [W-1:0] PERIOD;
    logic         VALID;
    logic         OVERRUN;
    logic         SATUR;
    logic         TIMEOUT;

    int checks   = 0;
    int failures = 0;

    prep2_capture #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .EVENT   (EVENT),
        .ACK     (ACK),
        .LDTHR   (LDTHR),
        .DATA    (DATA),
        .PERIOD  (PERIOD),
        .VALID   (VALID),
        .OVERRUN (OVERRUN),
        .SATUR   (SATUR),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse();
        EVENT = 1'b1;
        tick(1);
        EVENT = 1'b0;
    endtask

    task automatic low(input int n);
        EVENT = 1'b0;
        tick(n);
    endtask

    // Drop EN for one cycle with ACK high: IDLE, VALID/OVERRUN cleared.
    task automatic go_idle();
        ACK = 1'b1; EN = 1'b0; EVENT = 1'b0;
        tick(1);
        EN = 1'b1; ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; EN = 1'b0; EVENT = 1'b0; ACK = 1'b0; LDTHR = 1'b0; DATA = '0;
        tick(2);
        checks++;
        if ({PERIOD, VALID, OVERRUN, SATUR, TIMEOUT} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got P=%0d V=%b O=%b S=%b T=%b want all 0",
                     PERIOD, VALID, OVERRUN, SATUR, TIMEOUT);
        end
        RST = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        EN = 1'b1; ACK = 1'b1;
        pulse();
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL basic_first_edge VALID=%b want 0", VALID); end
        low(4);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd5) begin
            failures++; $display("FAIL basic_p5 VALID=%b PERIOD=%0d want 1/5", VALID, PERIOD);
        end
        low(1);
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL basic_ack_clear VALID=%b want 0", VALID); end
        low(5);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd7 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL basic_p7 V=%b P=%0d O=%b want 1/7/0", VALID, PERIOD, OVERRUN);
        end
    endtask

    task automatic test_overrun();
        go_idle();
        pulse();
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL ovr_arm VALID=%b want 0", VALID); end
        low(5);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd6 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL ovr_p6 V=%b P=%0d O=%b want 1/6/0", VALID, PERIOD, OVERRUN);
        end
        low(8);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd9 || OVERRUN !== 1'b1) begin
            failures++; $display("FAIL ovr_p9 V=%b P=%0d O=%b want 1/9/1", VALID, PERIOD, OVERRUN);
        end
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        checks++;
        if (VALID !== 1'b0 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL ovr_ack V=%b O=%b want 0/0", VALID, OVERRUN);
        end
    endtask

    task automatic test_timeout();
        go_idle();
        LDTHR = 1'b1; DATA = 8'd4;
        tick(1);
        LDTHR = 1'b0; DATA = '0;
        pulse();
        checks++;
        if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL to_armed TIMEOUT=%b want 0", TIMEOUT); end
        for (int k = 1; k <= 10; k++) begin
            low(1);
            checks++;
            if (TIMEOUT !== (k >= 4)) begin
                failures++; $display("FAIL to_cnt%0d TIMEOUT=%b want %b", k, TIMEOUT, (k >= 4));
            end
        end
        pulse();
        checks++;
        if (TIMEOUT !== 1'b0 || PERIOD !== 8'd11 || VALID !== 1'b1) begin
            failures++; $display("FAIL to_p11 T=%b P=%0d V=%b want 0/11/1", TIMEOUT, PERIOD, VALID);
        end
    endtask

    task automatic test_saturation();
        go_idle();
        LDTHR = 1'b1; DATA = 8'd0;
        tick(1);
        LDTHR = 1'b0;
        pulse();
        low(299);
        checks++;
        if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL sat_thr0 TIMEOUT=%b want 0", TIMEOUT); end
        pulse();
        checks++;
        if (PERIOD !== 8'd255 || SATUR !== 1'b1) begin
            failures++; $display("FAIL sat_300 P=%0d S=%b want 255/1", PERIOD, SATUR);
        end
        low(2);
        pulse();
        checks++;
        if (PERIOD !== 8'd3 || SATUR !== 1'b0) begin
            failures++; $display("FAIL sat_p3 P=%0d S=%b want 3/0", PERIOD, SATUR);
        end
        low(253);
        pulse();
        checks++;
        if (PERIOD !== 8'd254 || SATUR !== 1'b0) begin
            failures++; $display("FAIL sat_p254 P=%0d S=%b want 254/0", PERIOD, SATUR);
        end
        low(254);
        pulse();
        checks++;
        if (PERIOD !== 8'd255 || SATUR !== 1'b1) begin
            failures++; $display("FAIL sat_p255 P=%0d S=%b want 255/1", PERIOD, SATUR);
        end
        low(1);
        pulse();
        checks++;
        if (PERIOD !== 8'd2 || SATUR !== 1'b0) begin
            failures++; $display("FAIL sat_p2 P=%0d S=%b want 2/0", PERIOD, SATUR);
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        pulse();
        low(3);
        RST = 1'b0;
        #2;
        checks++;
        if ({PERIOD, VALID, OVERRUN, SATUR, TIMEOUT} !== 12'h000) begin
            failures++; $display("FAIL rst_mid P=%0d V=%b O=%b S=%b T=%b want all 0",
                                 PERIOD, VALID, OVERRUN, SATUR, TIMEOUT);
        end
        tick(1);
        RST = 1'b1;
        low(2);
        pulse();
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL rst_rearm VALID=%b want 0", VALID); end
        low(4);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd5) begin
            failures++; $display("FAIL rst_p5 V=%b P=%0d want 1/5", VALID, PERIOD);
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        pulse();
        low(3);
        EN = 1'b0;
        tick(1);
        EN = 1'b1;
        low(1);
        pulse();
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL en_rearm VALID=%b want 0", VALID); end
        low(3);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd4) begin
            failures++; $display("FAIL en_p4 V=%b P=%0d want 1/4", VALID, PERIOD);
        end
    endtask

    task automatic test_held_high();
        go_idle();
        EVENT = 1'b1;
        tick(3);
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("FAIL held_arm VALID=%b want 0", VALID); end
        low(2);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd5) begin
            failures++; $display("FAIL held_p5 V=%b P=%0d want 1/5", VALID, PERIOD);
        end
    endtask

    task automatic test_back_to_back();
        go_idle();
        pulse();
        low(4);
        pulse();
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd5 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL b2b_p5 V=%b P=%0d O=%b want 1/5/0", VALID, PERIOD, OVERRUN);
        end
        low(5);
        EVENT = 1'b1; ACK = 1'b1;
        tick(1);
        EVENT = 1'b0; ACK = 1'b0;
        checks++;
        if (VALID !== 1'b1 || PERIOD !== 8'd6 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL b2b_ack_cap V=%b P=%0d O=%b want 1/6/0", VALID, PERIOD, OVERRUN);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_en_drop();
        test_held_high();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
